// File: rtl/gcd_pkg.sv
// gcd_pkg: shared types and defaults for the GCD job feeder.
package gcd_pkg;
    localparam int GCD_DATA_W = 32;
    typedef enum logic [1:0] {IDLE, LOAD, RUN, RESP} state_t;
    typedef struct packed {
        logic [GCD_DATA_W-1:0] x;
        logic [GCD_DATA_W-1:0] y;
    } pair_t;
endpackage

// File: rtl/gcd_req_fifo.sv
// gcd_req_fifo: operand-pair FIFO, pointers carry an extra wrap bit for full/empty.
module gcd_req_fifo
    import gcd_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = pair_t
) (
    input  logic clk,
    input  logic rst,
    input  logic push_i,
    input  logic pop_i,
    input  T     wdata_i,
    output T     rdata_o,
    output logic full_o,
    output logic empty_o
);
    localparam int AW = $clog2(DEPTH);
    logic [AW:0] wr_q, rd_q;
    T            mem_q [DEPTH];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (push_i) wr_q <= wr_q + 1'b1;
            if (pop_i) rd_q <= rd_q + 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_q[AW-1:0]] <= wdata_i;
    end
    assign rdata_o = mem_q[rd_q[AW-1:0]];
    assign empty_o = wr_q == rd_q;
    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
endmodule

// File: rtl/gcd_job_feeder.sv
// gcd_job_feeder: queues operand pairs and runs them one at a time through the GCD core.
// Optional GCD_WATCHDOG_EN adds a RUN timeout reported on out_err.
module gcd_job_feeder
    import gcd_pkg::*;
#(
    parameter int DATA_W = GCD_DATA_W,
    parameter int DEPTH  = 4
`ifdef GCD_WATCHDOG_EN
    , parameter int TIMEOUT = 1024
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_x,
    input  logic [DATA_W-1:0] in_y,
    output logic              core_rst,
    output logic [DATA_W-1:0] core_x,
    output logic [DATA_W-1:0] core_y,
    input  logic              core_done,
    input  logic [DATA_W-1:0] core_result,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result
`ifdef GCD_WATCHDOG_EN
    , output logic            out_err
`endif
);
    typedef struct packed {
        logic [DATA_W-1:0] x;
        logic [DATA_W-1:0] y;
    } pair_w_t;
    state_t            state_q;
    logic              first_q, core_rst_q, out_valid_q;
    logic [DATA_W-1:0] core_x_q, core_y_q, out_result_q;
    logic              full, empty, push, pop;
    pair_w_t           head;
    assign in_ready = !rst && !full;
    assign push     = in_valid && in_ready;
    assign pop      = (state_q == IDLE) && !empty;
    gcd_req_fifo #(.DEPTH(DEPTH), .T(pair_w_t)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i ('{x: in_x, y: in_y}),
        .rdata_o (head),
        .full_o  (full),
        .empty_o (empty)
    );
`ifdef GCD_WATCHDOG_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt_q;
    logic          err_q;
    assign out_err = err_q;
`endif
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            first_q      <= 1'b0;
            core_rst_q   <= 1'b1;
            core_x_q     <= '0;
            core_y_q     <= '0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
`ifdef GCD_WATCHDOG_EN
            cnt_q        <= '0;
            err_q        <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: if (!empty) begin
                    core_x_q <= head.x;
                    core_y_q <= head.y;
                    // a zero operand would hang the subtractive core; x|y is the answer
                    if (head.x == '0 || head.y == '0) begin
                        out_result_q <= head.x | head.y;
                        out_valid_q  <= 1'b1;
                        state_q      <= RESP;
                    end else begin
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    core_rst_q <= 1'b0;
                    first_q    <= 1'b1;
                    state_q    <= RUN;
`ifdef GCD_WATCHDOG_EN
                    cnt_q      <= '0;
`endif
                end
                RUN: begin
                    first_q <= 1'b0;
`ifdef GCD_WATCHDOG_EN
                    cnt_q   <= (cnt_q == CW'(TIMEOUT)) ? cnt_q : cnt_q + 1'b1;
`endif
                    // done seen in the first RUN cycle may be left over from the previous job
                    if (core_done && !first_q) begin
                        out_result_q <= core_result;
                        out_valid_q  <= 1'b1;
                        state_q      <= RESP;
                    end
`ifdef GCD_WATCHDOG_EN
                    else if (cnt_q == CW'(TIMEOUT - 1)) begin
                        out_result_q <= '0;
                        out_valid_q  <= 1'b1;
                        err_q        <= 1'b1;
                        state_q      <= RESP;
                    end
`endif
                end
                RESP: if (out_ready) begin
                    out_valid_q <= 1'b0;
                    core_rst_q  <= 1'b1;
                    state_q     <= IDLE;
`ifdef GCD_WATCHDOG_EN
                    err_q       <= 1'b0;
`endif
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign core_rst   = core_rst_q;
    assign core_x     = core_x_q;
    assign core_y     = core_y_q;
    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;
endmodule

// File: tb/tb_gcd_job_feeder.sv
// tb_gcd_job_feeder: directed scoreboard bench with a fixed-latency GCD core model.
module tb_gcd_job_feeder;
    logic        clk = 0, rst = 1;
    logic        in_valid = 0, in_ready, out_valid, out_ready = 0;
    logic [31:0] in_x = 0, in_y = 0, core_x, core_y, core_result, out_result;
    logic        core_rst, core_done;
`ifdef GCD_WATCHDOG_EN
    logic        out_err;
`endif
    typedef struct {
        logic [31:0] r;
        logic        e;
    } exp_t;
    exp_t q[$];
    int total = 0, bad = 0;
    always #5 clk = ~clk;

    gcd_job_feeder #(
        .DATA_W(32), .DEPTH(4)
`ifdef GCD_WATCHDOG_EN
        , .TIMEOUT(16)
`endif
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_x(in_x), .in_y(in_y), .core_rst(core_rst), .core_x(core_x),
        .core_y(core_y), .core_done(core_done), .core_result(core_result),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result)
`ifdef GCD_WATCHDOG_EN
        , .out_err(out_err)
`endif
    );

    function automatic logic [31:0] gcd(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] t;
        while (b != 0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    // core model: loads on core_rst, raises done 10 cycles later; garbage result otherwise
    logic [31:0] mx = 0, my = 0;
    int          mcnt = 0;
    logic        mdone = 0, stale = 0, hang = 0;
    always @(posedge clk) begin
        if (core_rst) begin
            mx <= core_x;
            my <= core_y;
            mcnt <= 0;
            mdone <= 0;
        end else if (mcnt < 10) mcnt <= mcnt + 1;
        else if (!hang) mdone <= 1;
    end
    assign core_done   = mdone | stale;
    assign core_result = mdone ? gcd(mx, my) : 32'hDEAD;

    logic        hold = 0, zmon = 0;
    logic [31:0] hres = 0;
    int          zlow = 0;
    always @(negedge clk) begin
        if (rst) hold = 0;
        else begin
            if (hold) begin
                total++;
                assert (out_valid === 1'b1 && out_result === hres) else begin
                    bad++;
                    $error("FAIL hold valid=%0b res=%0d expected valid=1 res=%0d", out_valid, out_result, hres);
                end
            end
            if (out_valid && out_ready) begin
                total++;
                assert (q.size() != 0) else begin
                    bad++;
                    $error("FAIL unexpected_out res=%0d expected none", out_result);
                end
                if (q.size() != 0) begin
                    exp_t e;
                    e = q.pop_front();
                    total++;
                    assert (out_result === e.r) else begin
                        bad++;
                        $error("FAIL result got=%0d expected=%0d", out_result, e.r);
                    end
`ifdef GCD_WATCHDOG_EN
                    total++;
                    assert (out_err === e.e) else begin
                        bad++;
                        $error("FAIL out_err got=%0b expected=%0b", out_err, e.e);
                    end
`endif
                end
            end
            hold = out_valid && !out_ready;
            hres = out_result;
            if (zmon && !core_rst) zlow++;
        end
    end

    task automatic push(input logic [31:0] x, input logic [31:0] y, input logic [31:0] r,
                        input logic e, input bit track);
        int t = 0;
        @(negedge clk);
        in_valid = 1;
        in_x = x;
        in_y = y;
        if (track) q.push_back('{r: r, e: e});
        while (!in_ready && t < 500) begin
            @(negedge clk);
            t++;
        end
        total++;
        assert (t < 500) else begin
            bad++;
            $error("FAIL push_timeout waited=%0d limit=500", t);
        end
        @(posedge clk);
        #1 in_valid = 0;
    endtask

    task automatic drain();
        int t = 0;
        while ((q.size() != 0 || out_valid) && t < 2000) begin
            @(negedge clk);
            t++;
        end
        total++;
        assert (t < 2000) else begin
            bad++;
            $error("FAIL drain_timeout pending=%0d expected=0", q.size());
        end
    endtask

    task automatic wait_run();
        int t = 0;
        @(negedge clk);
        while (core_rst && t < 100) begin
            @(negedge clk);
            t++;
        end
        total++;
        assert (t < 100) else begin
            bad++;
            $error("FAIL run_timeout core_rst=%0b expected=0", core_rst);
        end
    endtask

    initial begin
        logic [31:0] px, py;
        int t;
        // reset state
        repeat (3) @(negedge clk);
        total++;
        assert (in_ready === 0 && core_rst === 1 && core_x === 0 && core_y === 0 &&
                out_valid === 0 && out_result === 0) else begin
            bad++;
            $error("FAIL reset rdy=%0b crst=%0b cx=%0d ov=%0d res=%0d expected 0 1 0 0 0",
                   in_ready, core_rst, core_x, out_valid, out_result);
        end
        @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        total++;
        assert (in_ready === 1) else begin
            bad++;
            $error("FAIL ready_after_reset got=%0b expected=1", in_ready);
        end
        // (48,18): observe load operands, hold result under backpressure
        push(48, 18, 6, 0, 1);
        px = 0; py = 0; t = 0;
        while (core_rst && t < 100) begin
            px = core_x;
            py = core_y;
            @(negedge clk);
            t++;
        end
        total++;
        assert (px === 48 && py === 18) else begin
            bad++;
            $error("FAIL load_operands x=%0d y=%0d expected 48 18", px, py);
        end
        t = 0;
        while (!out_valid && t < 100) begin
            @(negedge clk);
            t++;
        end
        total++;
        assert (out_valid === 1 && core_rst === 0) else begin
            bad++;
            $error("FAIL first_valid ov=%0b crst=%0b expected 1 0", out_valid, core_rst);
        end
        repeat (4) @(negedge clk);
        @(posedge clk);
        #1 out_ready = 1;
        drain();
        // zero operands resolved locally
        zmon = 1;
        zlow = 0;
        push(0, 25, 25, 0, 1);
        push(17, 0, 17, 0, 1);
        push(0, 0, 0, 0, 1);
        drain();
        zmon = 0;
        total++;
        assert (zlow === 0) else begin
            bad++;
            $error("FAIL zero_core_rst low_cycles=%0d expected=0", zlow);
        end
        // fill: one in flight plus DEPTH queued
        @(posedge clk);
        #1 out_ready = 0;
        push(12, 8, 4, 0, 1);
        push(35, 14, 7, 0, 1);
        push(9, 9, 9, 0, 1);
        push(100, 75, 25, 0, 1);
        push(13, 7, 1, 0, 1);
        @(negedge clk);
        total++;
        assert (in_ready === 0) else begin
            bad++;
            $error("FAIL full_ready got=%0b expected=0", in_ready);
        end
        @(posedge clk);
        #1 out_ready = 1;
        push(64, 48, 16, 0, 1);
        drain();
        // reset mid-job drops everything
        push(1000, 10, 10, 0, 0);
        wait_run();
        repeat (3) @(negedge clk);
        rst = 1;
        repeat (2) @(negedge clk);
        q.delete();
        rst = 0;
        @(negedge clk);
        total++;
        assert (out_valid === 0 && core_rst === 1) else begin
            bad++;
            $error("FAIL after_midrst ov=%0b crst=%0b expected 0 1", out_valid, core_rst);
        end
        push(21, 14, 7, 0, 1);
        drain();
        // stale done held into the first RUN cycle
        stale = 1;
        push(27, 18, 9, 0, 1);
        wait_run();
        @(posedge clk);
        #1 stale = 0;
        drain();
`ifdef GCD_WATCHDOG_EN
        hang = 1;
        push(5, 3, 0, 1, 1);
        wait_run();
        t = 0;
        while (!out_valid && t < 100) begin
            t++;
            @(negedge clk);
        end
        total++;
        assert (t === 16) else begin
            bad++;
            $error("FAIL watchdog_cycles got=%0d expected=16", t);
        end
        drain();
        hang = 0;
        push(10, 4, 2, 0, 1);
        drain();
`endif
        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
